// File: rtl/pic_inta_sequencer.sv
// 8259A control sequencer: raises INT, walks the 2/3-pulse INTA cycle and
// strobes the ISR/IRR/vector controls; also gates status reads and poll.
module pic_inta_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int ACK_TIMEOUT = 255,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       inta_n,
  input  logic       init_done,
  input  logic       icw4_upm,
  input  logic       icw4_aeoi,
  input  logic       int_request,
  input  logic       ocw3_change,
  input  logic [7:0] ocw3,
  input  logic       read_flag,
  output logic       int_out,
  output logic       int_request_ack,
  output logic       freezing,
  output logic       first_ack,
  output logic       send_vector,
  output logic       second_ack,
  output logic       aeoi_pulse,
  output logic       read_irr,
  output logic       read_isr,
  output logic       timeout_err
);

  typedef enum logic [2:0] {IDLE, REQ, ACK1, GAP1, ACK2, GAP2, ACK3, DONE} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   ack_prev_q, ack_prev_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   read_sel_q, read_sel_d;
  logic                   poll_pending_q, poll_pending_d;
  logic int_out_q, int_out_d, int_request_ack_q, int_request_ack_d;
  logic freezing_q, freezing_d, first_ack_q, first_ack_d;
  logic send_vector_q, send_vector_d, second_ack_q, second_ack_d;
  logic aeoi_pulse_q, aeoi_pulse_d, timeout_err_q, timeout_err_d;

  logic ack_fall, ack_rise, poll_hit, gap_expired, in_gap;
  logic unused_ocw3;

  assign unused_ocw3 = ^ocw3[7:3];
  assign ack_fall    = ack_prev_q & ~sync_q[SYNC_STAGES-1];
  assign ack_rise    = ~ack_prev_q & sync_q[SYNC_STAGES-1];
  assign in_gap      = (state_q == GAP1) || (state_q == GAP2);
  assign gap_expired = in_gap && (cnt_q == CNT_W'(ACK_TIMEOUT));
  assign poll_hit    = init_done && read_flag && poll_pending_q &&
                       ((state_q == IDLE) || (state_q == REQ));

  always_comb begin
    sync_d         = {sync_q[SYNC_STAGES-2:0], inta_n};
    ack_prev_d     = sync_q[SYNC_STAGES-1];
    state_d        = state_q;
    cnt_d          = '0;
    read_sel_d     = read_sel_q;
    poll_pending_d = poll_pending_q;

    case (state_q)
      IDLE: if (int_request) state_d = REQ;
      REQ: begin
        if (ack_fall)          state_d = ACK1;
        else if (!int_request) state_d = IDLE;
      end
      ACK1: if (ack_rise) state_d = GAP1;
      GAP1: begin
        if (ack_fall)         state_d = ACK2;
        else if (gap_expired) state_d = IDLE;
        else                  cnt_d   = cnt_q + CNT_W'(1);
      end
      ACK2: if (ack_rise) state_d = icw4_upm ? DONE : GAP2;
      GAP2: begin
        if (ack_fall)         state_d = ACK3;
        else if (gap_expired) state_d = IDLE;
        else                  cnt_d   = cnt_q + CNT_W'(1);
      end
      ACK3: if (ack_rise) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A poll read acts as a complete acknowledge in one cycle.
    if (poll_hit) state_d = IDLE;
    if (!init_done) begin
      state_d = IDLE;
      cnt_d   = '0;
    end

    // Clear first so a poll command arriving with the read re-arms it.
    if (poll_hit) poll_pending_d = 1'b0;
    if (ocw3_change) begin
      if (ocw3[1]) read_sel_d     = ocw3[0];
      if (ocw3[2]) poll_pending_d = 1'b1;
    end

    // Outputs are registered off the next-state decision.
    int_out_d         = (state_q == REQ) && (state_d == REQ);
    first_ack_d       = ((state_q == REQ) && (state_d == ACK1)) || poll_hit;
    int_request_ack_d = first_ack_d;
    freezing_d        = (state_d inside {ACK1, GAP1, ACK2, GAP2, ACK3}) || poll_hit;
    send_vector_d     = (state_d == ACK2) || (state_d == ACK3);
    second_ack_d      = (state_d == DONE);
    aeoi_pulse_d      = icw4_aeoi && ((state_d == DONE) || poll_hit);
    timeout_err_d     = init_done && gap_expired && !ack_fall;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q           <= IDLE;
      sync_q            <= '1;
      ack_prev_q        <= 1'b1;
      cnt_q             <= '0;
      read_sel_q        <= 1'b0;
      poll_pending_q    <= 1'b0;
      int_out_q         <= 1'b0;
      int_request_ack_q <= 1'b0;
      freezing_q        <= 1'b0;
      first_ack_q       <= 1'b0;
      send_vector_q     <= 1'b0;
      second_ack_q      <= 1'b0;
      aeoi_pulse_q      <= 1'b0;
      timeout_err_q     <= 1'b0;
    end else begin
      state_q           <= state_d;
      sync_q            <= sync_d;
      ack_prev_q        <= ack_prev_d;
      cnt_q             <= cnt_d;
      read_sel_q        <= read_sel_d;
      poll_pending_q    <= poll_pending_d;
      int_out_q         <= int_out_d;
      int_request_ack_q <= int_request_ack_d;
      freezing_q        <= freezing_d;
      first_ack_q       <= first_ack_d;
      send_vector_q     <= send_vector_d;
      second_ack_q      <= second_ack_d;
      aeoi_pulse_q      <= aeoi_pulse_d;
      timeout_err_q     <= timeout_err_d;
    end
  end

  assign int_out         = int_out_q;
  assign int_request_ack = int_request_ack_q;
  assign freezing        = freezing_q;
  assign first_ack       = first_ack_q;
  assign send_vector     = send_vector_q;
  assign second_ack      = second_ack_q;
  assign aeoi_pulse      = aeoi_pulse_q;
  assign timeout_err     = timeout_err_q;
  assign read_irr = read_flag && (state_q == IDLE) && !poll_pending_q && !read_sel_q;
  assign read_isr = read_flag && (state_q == IDLE) && !poll_pending_q &&  read_sel_q;

endmodule

// File: tb/tb_pic_inta_sequencer.sv
// Bench for pic_inta_sequencer: expected output waveforms are built from the
// pin schedule and the fixed pin-to-output latency, then compared per cycle.
module tb_pic_inta_sequencer;
  localparam int SS = 2;
  localparam int TO = 8;
  localparam int L  = SS + 1;
  localparam int B_INT = 9, B_IRA = 8, B_FRZ = 7, B_FA = 6, B_SV = 5;
  localparam int B_SA = 4, B_AE = 3, B_RIRR = 2, B_RISR = 1, B_TO = 0;

  logic clk = 1'b0, reset_n = 1'b0, inta_n = 1'b1, init_done = 1'b1;
  logic icw4_upm = 1'b1, icw4_aeoi = 1'b0, int_request = 1'b0;
  logic ocw3_change = 1'b0, read_flag = 1'b0;
  logic [7:0] ocw3 = 8'h00;
  logic int_out, int_request_ack, freezing, first_ack, send_vector;
  logic second_ack, aeoi_pulse, read_irr, read_isr, timeout_err;
  logic [9:0] outs;
  int checks = 0, errors = 0;
  bit model_sel = 1'b0, model_poll = 1'b0;

  assign outs = {int_out, int_request_ack, freezing, first_ack, send_vector,
                 second_ack, aeoi_pulse, read_irr, read_isr, timeout_err};

  pic_inta_sequencer #(.SYNC_STAGES(SS), .ACK_TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .inta_n(inta_n), .init_done(init_done),
    .icw4_upm(icw4_upm), .icw4_aeoi(icw4_aeoi), .int_request(int_request),
    .ocw3_change(ocw3_change), .ocw3(ocw3), .read_flag(read_flag),
    .int_out(int_out), .int_request_ack(int_request_ack), .freezing(freezing),
    .first_ack(first_ack), .send_vector(send_vector), .second_ack(second_ack),
    .aeoi_pulse(aeoi_pulse), .read_irr(read_irr), .read_isr(read_isr),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic test_reset;
    reset_n = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      inta_n = c[0]; int_request = 1'b1;
      @(negedge clk); checks++;
      if (outs !== 10'b0) begin
        errors++; $display("FAIL reset cycle %0d outs=%b expected=%b", c, outs, 10'b0);
      end
    end
    @(posedge clk); #1;
    inta_n = 1'b1; int_request = 1'b0; reset_n = 1'b1;
    model_sel = 1'b0; model_poll = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  // Full INTA cycle from a random pin schedule; optional abort by gap timeout,
  // optional request held high to exercise the post-DONE bubble.
  task automatic test_inta(input string name, input bit upm, input bit aeoi,
                           input bit tmo, input bit keep);
    int f[3]; int r[3]; int np, d, len, ireq_end;
    logic [9:0] exp [64];
    np = upm ? 2 : 3;
    f[0] = $urandom_range(1, 4);
    r[0] = f[0] + $urandom_range(1, 4);
    for (int i = 1; i < 3; i++) begin
      f[i] = r[i-1] + $urandom_range(1, TO + 1);
      r[i] = f[i] + $urandom_range(1, 4);
    end
    if (tmo) begin
      np = 2; f[1] = r[0] + TO + 2; r[1] = f[1] + 2;
      d = r[0] + L + TO + 1;
    end else d = r[np-1] + L;
    len = d + 6;
    ireq_end = (keep && !tmo) ? len : f[0] + L;
    for (int c = 0; c < 64; c++) exp[c] = '0;
    for (int c = 2; c < f[0] + L; c++) exp[c][B_INT] = 1'b1;
    exp[f[0]+L][B_FA]  = 1'b1;
    exp[f[0]+L][B_IRA] = 1'b1;
    for (int c = f[0] + L; c < d; c++) exp[c][B_FRZ] = 1'b1;
    if (tmo) exp[d][B_TO] = 1'b1;
    else begin
      for (int i = 1; i < np; i++)
        for (int c = f[i] + L; c < r[i] + L; c++) exp[c][B_SV] = 1'b1;
      exp[d][B_SA] = 1'b1;
      exp[d][B_AE] = aeoi;
      if (keep) for (int c = d + 3; c < len; c++) exp[c][B_INT] = 1'b1;
    end
    for (int c = 0; c < len; c++) begin
      @(posedge clk); #1;
      icw4_upm = upm; icw4_aeoi = aeoi; int_request = (c < ireq_end);
      inta_n = 1'b1;
      for (int i = 0; i < np; i++) if (c >= f[i] && c < r[i]) inta_n = 1'b0;
      @(negedge clk); checks++;
      if (outs !== exp[c]) begin
        errors++; $display("FAIL %s cycle %0d outs=%b expected=%b", name, c, outs, exp[c]);
      end
    end
    @(posedge clk); #1;
    int_request = 1'b0; inta_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); checks++;
    if (outs !== 10'b0) begin
      errors++; $display("FAIL %s_quiet outs=%b expected=%b", name, outs, 10'b0);
    end
  endtask

  task automatic test_withdraw;
    for (int n = 0; n < 3; n++) begin
      int h; logic [9:0] e;
      h = $urandom_range(1, 6);
      for (int c = 0; c < h + 5; c++) begin
        @(posedge clk); #1;
        int_request = (c < h); inta_n = 1'b1;
        e = '0;
        e[B_INT] = (c >= 2 && c <= h);
        @(negedge clk); checks++;
        if (outs !== e) begin
          errors++; $display("FAIL withdraw h=%0d cycle %0d outs=%b expected=%b", h, c, outs, e);
        end
      end
    end
  endtask

  task automatic test_ocw3;
    bit dchg [7] = '{1, 0, 1, 0, 0, 1, 0};
    logic [7:0] dval [7] = '{8'h0B, 8'h00, 8'h0C, 8'h00, 8'h00, 8'h0A, 8'h00};
    bit drf [7] = '{0, 1, 0, 1, 1, 1, 1};
    bit chg, rf, hit_prev, aeoi;
    logic [7:0] val;
    logic [9:0] e;
    aeoi = 1'($urandom_range(0, 1));
    hit_prev = 1'b0;
    for (int k = 0; k < 48; k++) begin
      if (k < 7) begin
        chg = dchg[k]; val = dval[k]; rf = drf[k];
      end else if (k < 47) begin
        chg = ($urandom_range(0, 3) == 0); val = 8'($urandom); rf = ($urandom_range(0, 2) == 0);
      end else begin
        chg = 1'b0; val = 8'h00; rf = 1'b0;
      end
      @(posedge clk); #1;
      ocw3_change = chg; ocw3 = val; read_flag = rf; icw4_aeoi = aeoi; int_request = 1'b0;
      e = '0;
      e[B_FA] = hit_prev; e[B_IRA] = hit_prev; e[B_FRZ] = hit_prev;
      e[B_AE] = hit_prev && aeoi;
      e[B_RIRR] = rf && !model_poll && !model_sel;
      e[B_RISR] = rf && !model_poll && model_sel;
      @(negedge clk); checks++;
      if (outs !== e) begin
        errors++; $display("FAIL ocw3_read step %0d outs=%b expected=%b", k, outs, e);
      end
      hit_prev = rf && model_poll;
      if (hit_prev) model_poll = 1'b0;
      if (chg && val[2]) model_poll = 1'b1;
      if (chg && val[1]) model_sel = val[0];
    end
    @(posedge clk); #1;
    ocw3_change = 1'b0; read_flag = 1'b0;
  endtask

  task automatic test_reset_mid;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      icw4_upm = 1'b1; int_request = 1'b1;
      inta_n = !((c >= 3 && c < 5) || c >= 7);
      @(negedge clk);
    end
    checks++;
    if (send_vector !== 1'b1 || freezing !== 1'b1) begin
      errors++; $display("FAIL reset_mid_pre send_vector=%b freezing=%b expected=1 1", send_vector, freezing);
    end
    #2 reset_n = 1'b0;
    #1 checks++;
    if (outs !== 10'b0) begin
      errors++; $display("FAIL reset_mid outs=%b expected=%b", outs, 10'b0);
    end
    model_sel = 1'b0; model_poll = 1'b0;
    inta_n = 1'b1; int_request = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_init_drop;
    logic [9:0] e;
    for (int c = 0; c < 11; c++) begin
      @(posedge clk); #1;
      int_request = (c < 5); init_done = !(c == 8 || c == 9);
      inta_n = !(c >= 2 && c < 4);
      @(negedge clk);
      if (c == 5) begin
        checks++; e = '0; e[B_FA] = 1'b1; e[B_IRA] = 1'b1; e[B_FRZ] = 1'b1;
        if (outs !== e) begin
          errors++; $display("FAIL init_drop_ack outs=%b expected=%b", outs, e);
        end
      end
      if (c == 8) begin
        checks++;
        if (freezing !== 1'b1) begin
          errors++; $display("FAIL init_drop_gap freezing=%b expected=1", freezing);
        end
      end
      if (c == 9) begin
        checks++;
        if (outs !== 10'b0) begin
          errors++; $display("FAIL init_drop_idle outs=%b expected=%b", outs, 10'b0);
        end
      end
    end
    // Read select survives re-init.
    @(posedge clk); #1;
    read_flag = 1'b1;
    e = '0; e[B_RIRR] = !model_poll && !model_sel; e[B_RISR] = !model_poll && model_sel;
    @(negedge clk); checks++;
    if (outs !== e) begin
      errors++; $display("FAIL init_drop_read outs=%b expected=%b", outs, e);
    end
    if (model_poll) model_poll = 1'b0;
    @(posedge clk); #1 read_flag = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    test_reset;
    test_ocw3;
    for (int n = 0; n < 3; n++) test_inta("inta_8086", 1'b1, 1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 3; n++) test_inta("inta_8080", 1'b0, 1'b1, 1'b0, 1'b0);
    for (int n = 0; n < 4; n++)
      test_inta("inta_rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    for (int n = 0; n < 3; n++) test_inta("timeout", 1'b1, 1'b1, 1'b1, 1'b0);
    test_inta("back_to_back", 1'b1, 1'b1, 1'b0, 1'b1);
    test_inta("back_to_back_8080", 1'b0, 1'b0, 1'b0, 1'b1);
    test_withdraw;
    test_reset_mid;
    test_init_drop;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
